tt_puf_driver: RTL

Challenge/response sequencer that drives the arbiter multiplexer chain (`pulse`, `key_4`) and collects its one-bit race result (`multblockout`) into a multi-bit response word. For each response bit it derives a challenge from a latched base challenge, fires the chain `VOTES` times, and majority-votes the synchronized arbiter outputs. It sits between the user interface and the arbiter block, owns all timing of the race launch, and presents the finished word through a valid/ready handshake.

---
 rtl/tt_puf_driver.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/tt_puf_driver.sv
`default_nettype none
// ============================================================================
// Module   : tt_puf_driver
// Purpose  : Challenge/response sequencer for an arbiter-PUF multiplexer
//            chain. For each response bit it derives a per-bit challenge from
//            a latched base challenge. It fires the chain VOTES times and
//            majority-votes the synchronized arbiter result. The finished word
//            is presented through a valid/ready handshake.
// Ports    : clk, rst_n (sync, active-low)
//            start, challenge[3:0]        - measurement request / base chal
//            busy                         - high outside IDLE
//            pulse, key_4[3:0]            - registered race launch + challenge
//            multblockout                 - asynchronous arbiter result
//            response[RESP_BITS-1:0]      - assembled response word
//            resp_valid, resp_ready       - response handshake
// Revision : 1.0 - initial release
// ============================================================================
module tt_puf_driver #(
    parameter int unsigned RESP_BITS  = 8,
    parameter int unsigned VOTES      = 3,
    parameter int unsigned PRE_CYC    = 4,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           challenge,
    output logic                 busy,
    output logic                 pulse,
    output logic [3:0]           key_4,
    input  logic                 multblockout,
    output logic [RESP_BITS-1:0] response,
    output logic                 resp_valid,
    input  logic                 resp_ready
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_PRE  = 2'd1;
    localparam logic [1:0] c_FIRE = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam int unsigned c_CYC_MAX = (PRE_CYC > SETTLE_CYC) ? PRE_CYC : SETTLE_CYC;
    localparam int unsigned c_CYC_W   = (c_CYC_MAX > 1) ? $clog2(c_CYC_MAX) : 1;

    localparam logic [c_CYC_W-1:0] c_PRE_LAST = c_CYC_W'(PRE_CYC - 1);
    localparam logic [c_CYC_W-1:0] c_SET_LAST = c_CYC_W'(SETTLE_CYC - 1);
    localparam logic [3:0]         c_VOTE_LAST = 4'(VOTES - 1);
    localparam logic [3:0]         c_MAJ       = 4'(VOTES / 2);
    localparam logic [3:0]         c_BIT_LAST  = 4'(RESP_BITS - 1);

    logic [1:0]           state_q,    state_d;
    logic [3:0]           chal_q,     chal_d;
    logic [3:0]           bit_idx_q,  bit_idx_d;
    logic [3:0]           vote_cnt_q, vote_cnt_d;
    logic [3:0]           ones_q,     ones_d;
    logic [c_CYC_W-1:0]   cyc_q,      cyc_d;
    logic [RESP_BITS-1:0] resp_q,     resp_d;
    logic                 pulse_q,    pulse_d;
    logic [3:0]           key_q,      key_d;
    logic                 sync1_q,    sync2_q;
    logic [3:0]           w_ones_inc;

    // Ones count including the sample taken on this (last FIRE) cycle
    assign w_ones_inc = ones_q + {3'b000, sync2_q};

    always_comb begin
        state_d    = state_q;
        chal_d     = chal_q;
        bit_idx_d  = bit_idx_q;
        vote_cnt_d = vote_cnt_q;
        ones_d     = ones_q;
        cyc_d      = cyc_q;
        resp_d     = resp_q;

        case (state_q)
            c_IDLE: begin
                if (start) begin
                    chal_d     = challenge;
                    bit_idx_d  = 4'd0;
                    vote_cnt_d = 4'd0;
                    ones_d     = 4'd0;
                    cyc_d      = '0;
                    resp_d     = '0;
                    state_d    = c_PRE;
                end
            end
            c_PRE: begin
                if (cyc_q == c_PRE_LAST) begin
                    cyc_d   = '0;
                    state_d = c_FIRE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            c_FIRE: begin
                if (cyc_q == c_SET_LAST) begin
                    cyc_d   = '0;
                    state_d = c_PRE;
                    if (vote_cnt_q == c_VOTE_LAST) begin
                        // Last race of this bit: resolve the majority vote
                        for (int unsigned i = 0; i < RESP_BITS; i++) begin
                            if (bit_idx_q == 4'(i)) begin
                                resp_d[i] = (w_ones_inc > c_MAJ);
                            end
                        end
                        vote_cnt_d = 4'd0;
                        ones_d     = 4'd0;
                        if (bit_idx_q == c_BIT_LAST) begin
                            state_d = c_DONE;
                        end else begin
                            bit_idx_d = bit_idx_q + 4'd1;
                        end
                    end else begin
                        vote_cnt_d = vote_cnt_q + 4'd1;
                        ones_d     = w_ones_inc;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: begin // c_DONE
                if (resp_ready) begin
                    state_d = c_IDLE;
                end
            end
        endcase

        // Launch outputs are registered from next-state values so they line
        // up with the state they belong to; key only moves when bit_idx does,
        // which happens on entry to the first PRECHARGE of a new bit.
        pulse_d = (state_d == c_FIRE);
        key_d   = ((state_d == c_PRE) || (state_d == c_FIRE)) ? (chal_d ^ bit_idx_d) : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= c_IDLE;
            chal_q     <= 4'd0;
            bit_idx_q  <= 4'd0;
            vote_cnt_q <= 4'd0;
            ones_q     <= 4'd0;
            cyc_q      <= '0;
            resp_q     <= '0;
            pulse_q    <= 1'b0;
            key_q      <= 4'd0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            chal_q     <= chal_d;
            bit_idx_q  <= bit_idx_d;
            vote_cnt_q <= vote_cnt_d;
            ones_q     <= ones_d;
            cyc_q      <= cyc_d;
            resp_q     <= resp_d;
            pulse_q    <= pulse_d;
            key_q      <= key_d;
            sync1_q    <= multblockout;
            sync2_q    <= sync1_q;
        end
    end

    assign busy       = (state_q != c_IDLE);
    assign resp_valid = (state_q == c_DONE);
    assign pulse      = pulse_q;
    assign key_4      = key_q;
    assign response   = resp_q;

endmodule
`default_nettype wire
